// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer that fetches the reset vector, then applies MPC hold/inc/load/jump.
// Define PC_ALIGN_CHECK_EN to add the odd-address FAULT state and the pc_fault output.
module pc_seq #(
    parameter logic [15:0] RESET_VEC = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  MPC,
    input  logic [2:0]  jmp_cond,
    input  logic [9:0]  jmp_off,
    input  logic [3:0]  SR_flags,
    input  logic [15:0] MDB_out,
    input  logic        mem_ready,
    output logic [15:0] reg_PC_out,
    output logic [15:0] pc_MAB,
    output logic        fetch_req,
    output logic        pc_valid,
`ifdef PC_ALIGN_CHECK_EN
    output logic        pc_fault,
`endif
    output logic        jmp_taken
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {VEC_REQ, RUN, FAULT} state_t;
`else
    typedef enum logic [1:0] {VEC_REQ, RUN} state_t;
`endif

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_plus2;

    // SR_flags packs {V,N,Z,C}
    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] flags);
        logic v, n, z, c;
        v = flags[3];
        n = flags[2];
        z = flags[1];
        c = flags[0];
        case (cond)
            3'd0:    return ~z;
            3'd1:    return z;
            3'd2:    return ~c;
            3'd3:    return c;
            3'd4:    return n;
            3'd5:    return ~(n ^ v);
            3'd6:    return n ^ v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] jump_disp(input logic [9:0] off);
        return {{5{off[9]}}, off, 1'b0};
    endfunction

    function automatic logic [15:0] word_addr(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

    assign pc_plus2   = pc + 16'd2;
    assign reg_PC_out = pc;
    assign pc_MAB     = (state == VEC_REQ) ? RESET_VEC : pc;
`ifdef PC_ALIGN_CHECK_EN
    assign fetch_req  = (state != FAULT);
`else
    assign fetch_req  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= VEC_REQ;
            pc        <= 16'h0000;
            jmp_taken <= 1'b0;
            pc_valid  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            pc_fault  <= 1'b0;
`endif
        end else begin
            jmp_taken <= 1'b0;
            case (state)
                VEC_REQ: begin
                    if (mem_ready) begin
                        pc <= word_addr(MDB_out);
`ifdef PC_ALIGN_CHECK_EN
                        if (MDB_out[0]) begin
                            state    <= FAULT;
                            pc_fault <= 1'b1;
                        end else begin
                            state    <= RUN;
                            pc_valid <= 1'b1;
                        end
`else
                        state    <= RUN;
                        pc_valid <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    case (MPC)
                        3'd1: if (mem_ready) pc <= pc_plus2;
                        3'd2: begin
                            if (mem_ready) begin
                                pc <= word_addr(MDB_out);
`ifdef PC_ALIGN_CHECK_EN
                                if (MDB_out[0]) begin
                                    state    <= FAULT;
                                    pc_fault <= 1'b1;
                                    pc_valid <= 1'b0;
                                end
`endif
                            end
                        end
                        // Jumps advance regardless of mem_ready; the offset is relative to PC+2
                        3'd3: begin
                            if (cond_met(jmp_cond, SR_flags)) begin
                                pc        <= pc_plus2 + jump_disp(jmp_off);
                                jmp_taken <= 1'b1;
                            end else begin
                                pc <= pc_plus2;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus randomized MPC traffic against an arithmetic model.
module tb_pc_seq;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  MPC;
    logic [2:0]  jmp_cond;
    logic [9:0]  jmp_off;
    logic [3:0]  SR_flags;
    logic [15:0] MDB_out;
    logic        mem_ready;
    logic [15:0] reg_PC_out;
    logic [15:0] pc_MAB;
    logic        fetch_req;
    logic        pc_valid;
    logic        jmp_taken;
`ifdef PC_ALIGN_CHECK_EN
    logic        pc_fault;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_pc;
    bit m_run;
    bit m_fault;
    bit m_taken;

    pc_seq dut (
        .clk(clk), .rst(rst), .MPC(MPC), .jmp_cond(jmp_cond), .jmp_off(jmp_off),
        .SR_flags(SR_flags), .MDB_out(MDB_out), .mem_ready(mem_ready),
        .reg_PC_out(reg_PC_out), .pc_MAB(pc_MAB), .fetch_req(fetch_req),
        .pc_valid(pc_valid),
`ifdef PC_ALIGN_CHECK_EN
        .pc_fault(pc_fault),
`endif
        .jmp_taken(jmp_taken)
    );

    always #5 clk = ~clk;

    function automatic bit cond_true(input logic [2:0] c, input logic [3:0] f);
        bit v, n, z, cy;
        v = f[3]; n = f[2]; z = f[1]; cy = f[0];
        case (c)
            3'd0: return z == 0;
            3'd1: return z == 1;
            3'd2: return cy == 0;
            3'd3: return cy == 1;
            3'd4: return n == 1;
            3'd5: return (n != v) == 0;
            3'd6: return (n != v) == 1;
            default: return 1;
        endcase
    endfunction

    function automatic int wrap16(input int x);
        return ((x % 65536) + 65536) % 65536;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_run = 0; m_fault = 0; m_taken = 0;
    endtask

    // advance model with the current inputs, then clock the DUT and settle
    task automatic cycle();
        int off;
        bit t;
        m_taken = 0;
        if (!m_fault) begin
            if (!m_run) begin
                if (mem_ready) begin
                    m_pc = int'(MDB_out) - (MDB_out[0] ? 1 : 0);
                    if (ALIGN && MDB_out[0]) m_fault = 1; else m_run = 1;
                end
            end else begin
                case (MPC)
                    3'd1: if (mem_ready) m_pc = wrap16(m_pc + 2);
                    3'd2: if (mem_ready) begin
                        m_pc = int'(MDB_out) - (MDB_out[0] ? 1 : 0);
                        if (ALIGN && MDB_out[0]) begin m_fault = 1; m_run = 0; end
                    end
                    3'd3: begin
                        off = int'(jmp_off) - (jmp_off[9] ? 1024 : 0);
                        t = cond_true(jmp_cond, SR_flags);
                        m_pc = wrap16(m_pc + 2 + (t ? 2 * off : 0));
                        m_taken = t;
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MPC = 3'd0; jmp_cond = 3'd0; jmp_off = 10'd0; SR_flags = 4'd0;
        MDB_out = 16'd0; mem_ready = 1'b0;
    endtask

    task automatic boot(input logic [15:0] vec);
        rst = 1'b1; idle_inputs(); model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        MDB_out = vec; mem_ready = 1'b1;
        cycle();
        mem_ready = 1'b0;
    endtask

    task automatic load_pc(input logic [15:0] a);
        MPC = 3'd2; MDB_out = a; mem_ready = 1'b1;
        cycle();
        MPC = 3'd0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (reg_PC_out !== 16'h0000 || pc_valid !== 1'b0 || jmp_taken !== 1'b0)
            $display("FAIL reset_regs got pc=%h valid=%b taken=%b want pc=0000 valid=0 taken=0",
                     reg_PC_out, pc_valid, jmp_taken);
        else n_pass++;
        n_checks++;
        if (pc_MAB !== 16'hFFFE || fetch_req !== 1'b1)
            $display("FAIL reset_fetch got mab=%h req=%b want mab=fffe req=1", pc_MAB, fetch_req);
        else n_pass++;
`ifdef PC_ALIGN_CHECK_EN
        n_checks++;
        if (pc_fault !== 1'b0) $display("FAIL reset_fault got %b want 0", pc_fault);
        else n_pass++;
`endif
    endtask

    task automatic test_vector_fetch();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (pc_MAB !== 16'hFFFE || pc_valid !== 1'b0 || fetch_req !== 1'b1)
                $display("FAIL vec_wait%0d got mab=%h valid=%b req=%b want mab=fffe valid=0 req=1",
                         i, pc_MAB, pc_valid, fetch_req);
            else n_pass++;
        end
        MDB_out = 16'hC000; mem_ready = 1'b1; MPC = 3'd1;
        cycle();
        n_checks++;
        if (reg_PC_out !== 16'hC000 || pc_valid !== 1'b1 || pc_MAB !== 16'hC000)
            $display("FAIL vec_load got pc=%h valid=%b mab=%h want pc=c000 valid=1 mab=c000",
                     reg_PC_out, pc_valid, pc_MAB);
        else n_pass++;
    endtask

    task automatic test_increment_stall();
        logic [15:0] exp_seq [3];
        logic        rdy_seq [3];
        exp_seq = '{16'hC002, 16'hC002, 16'hC004};
        rdy_seq = '{1'b1, 1'b0, 1'b1};
        MPC = 3'd1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = rdy_seq[i];
            cycle();
            n_checks++;
            if (reg_PC_out !== exp_seq[i])
                $display("FAIL inc_step%0d got pc=%h want %h", i, reg_PC_out, exp_seq[i]);
            else n_pass++;
        end
        MPC = 3'd0; mem_ready = 1'b0;
    endtask

    task automatic test_jumps();
        load_pc(16'hC010);
        MPC = 3'd3; jmp_cond = 3'd1; SR_flags = 4'b0010; jmp_off = 10'h005;
        cycle();
        n_checks++;
        if (reg_PC_out !== 16'hC01C || jmp_taken !== 1'b1)
            $display("FAIL jeq_taken got pc=%h taken=%b want c01c 1", reg_PC_out, jmp_taken);
        else n_pass++;
        MPC = 3'd0;
        cycle();
        n_checks++;
        if (jmp_taken !== 1'b0 || reg_PC_out !== 16'hC01C)
            $display("FAIL jeq_pulse_end got pc=%h taken=%b want c01c 0", reg_PC_out, jmp_taken);
        else n_pass++;

        load_pc(16'hC010);
        MPC = 3'd3; jmp_cond = 3'd1; SR_flags = 4'b0000; jmp_off = 10'h005;
        cycle();
        n_checks++;
        if (reg_PC_out !== 16'hC012 || jmp_taken !== 1'b0)
            $display("FAIL jeq_not_taken got pc=%h taken=%b want c012 0", reg_PC_out, jmp_taken);
        else n_pass++;

        load_pc(16'hC010);
        MPC = 3'd3; jmp_cond = 3'd6; SR_flags = 4'b0100; jmp_off = 10'h3FE; mem_ready = 1'b0;
        cycle();
        n_checks++;
        if (reg_PC_out !== 16'hC00E || jmp_taken !== 1'b1)
            $display("FAIL jl_back got pc=%h taken=%b want c00e 1", reg_PC_out, jmp_taken);
        else n_pass++;
        MPC = 3'd0;
    endtask

    task automatic test_wrap();
        load_pc(16'hFFFE);
        MPC = 3'd1; mem_ready = 1'b1;
        cycle();
        n_checks++;
        if (reg_PC_out !== 16'h0000) $display("FAIL inc_wrap got pc=%h want 0000", reg_PC_out);
        else n_pass++;
        load_pc(16'hFFFC);
        MPC = 3'd3; jmp_cond = 3'd7; SR_flags = 4'b0000; jmp_off = 10'h1FF;
        cycle();
        n_checks++;
        if (reg_PC_out !== 16'h03FC) $display("FAIL jmp_wrap got pc=%h want 03fc", reg_PC_out);
        else n_pass++;
        MPC = 3'd0;
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        for (int i = 0; i < 300; i++) begin
            MPC       = 3'($urandom_range(0, 7));
            jmp_cond  = 3'($urandom);
            jmp_off   = 10'($urandom);
            SR_flags  = 4'($urandom);
            MDB_out   = 16'($urandom) & 16'hFFFE;
            mem_ready = 1'($urandom);
            cycle();
            exp_pc = 16'(m_pc);
            n_checks++;
            if (reg_PC_out !== exp_pc || jmp_taken !== m_taken || pc_valid !== 1'b1 ||
                pc_MAB !== exp_pc || fetch_req !== 1'b1)
                $display("FAIL rand%0d got pc=%h taken=%b valid=%b mab=%h req=%b want pc=%h taken=%b valid=1 req=1",
                         i, reg_PC_out, jmp_taken, pc_valid, pc_MAB, fetch_req, exp_pc, m_taken);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_load_fault();
        load_pc(16'h8001);
        n_checks++;
        if (reg_PC_out !== 16'h8000) $display("FAIL odd_load_pc got %h want 8000", reg_PC_out);
        else n_pass++;
        MPC = 3'd1; mem_ready = 1'b1;
        cycle();
        cycle();
`ifdef PC_ALIGN_CHECK_EN
        n_checks++;
        if (reg_PC_out !== 16'h8000 || pc_fault !== 1'b1 || fetch_req !== 1'b0 || pc_valid !== 1'b0)
            $display("FAIL fault_hold got pc=%h fault=%b req=%b valid=%b want 8000 1 0 0",
                     reg_PC_out, pc_fault, fetch_req, pc_valid);
        else n_pass++;
`else
        n_checks++;
        if (reg_PC_out !== 16'h8004 || fetch_req !== 1'b1 || pc_valid !== 1'b1)
            $display("FAIL odd_continue got pc=%h req=%b valid=%b want 8004 1 1",
                     reg_PC_out, fetch_req, pc_valid);
        else n_pass++;
`endif
        idle_inputs();
    endtask

    task automatic test_async_reset();
        boot(16'hC000);
        MPC = 3'd3; jmp_cond = 3'd7; jmp_off = 10'h004;
        cycle();
        n_checks++;
        if (jmp_taken !== 1'b1 || reg_PC_out !== 16'hC00A)
            $display("FAIL pre_reset_jmp got pc=%h taken=%b want c00a 1", reg_PC_out, jmp_taken);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (reg_PC_out !== 16'h0000 || jmp_taken !== 1'b0 || pc_valid !== 1'b0 ||
            pc_MAB !== 16'hFFFE || fetch_req !== 1'b1)
            $display("FAIL async_reset got pc=%h taken=%b valid=%b mab=%h req=%b want 0000 0 0 fffe 1",
                     reg_PC_out, jmp_taken, pc_valid, pc_MAB, fetch_req);
        else n_pass++;
        model_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_vector_fetch();
        test_increment_stall();
        test_jumps();
        test_wrap();
        test_random();
        test_load_fault();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
